// File: rtl/exu_alu_muldiv_pkg.sv
// exu_alu_muldiv_pkg: shared widths, op and state encodings for the iterative multiplier
`ifndef EXU_ALU_MULDIV_DEFS
`define EXU_ALU_MULDIV_DEFS
`define XLEN 32
`define ALU_ADDER_WIDTH `XLEN
`endif

package exu_alu_muldiv_pkg;
   typedef enum logic [1:0] {
      MULDIV_OP_MUL    = 2'b00,
      MULDIV_OP_MULH   = 2'b01,
      MULDIV_OP_MULHSU = 2'b10,
      MULDIV_OP_MULHU  = 2'b11
   } muldiv_op_e;
   typedef enum logic [1:0] {
      MULDIV_ST_IDLE = 2'b00,
      MULDIV_ST_CALC = 2'b01,
      MULDIV_ST_FIX  = 2'b10,
      MULDIV_ST_DONE = 2'b11
   } muldiv_st_e;
   function automatic logic rs1_signed(input muldiv_op_e op);
      return op == MULDIV_OP_MULH || op == MULDIV_OP_MULHSU;
   endfunction
endpackage

// File: rtl/exu_alu_muldiv_if.sv
// exu_alu_muldiv_if: issue and writeback handshakes of the multiplier
interface exu_alu_muldiv_if
   import exu_alu_muldiv_pkg::*;
#(parameter int XLEN = `XLEN);
   logic            i_valid;
   logic            i_ready;
   muldiv_op_e      i_op;
   logic [XLEN-1:0] i_rs1;
   logic [XLEN-1:0] i_rs2;
   logic            i_flush;
   logic            o_valid;
   logic            o_ready;
   logic [XLEN-1:0] o_wdat;
   modport master (output i_valid, i_op, i_rs1, i_rs2, i_flush, o_ready,
                   input  i_ready, o_valid, o_wdat);
   modport slave  (input  i_valid, i_op, i_rs1, i_rs2, i_flush, o_ready,
                   output i_ready, o_valid, o_wdat);
endinterface

// File: rtl/exu_alu_muldiv_abs.sv
// muldiv_abs: combinational conditional two's-complement negate
module muldiv_abs #(parameter int W = 32) (
   input  logic [W-1:0] i_a,
   input  logic         i_neg,
   output logic [W-1:0] o_y
);
   assign o_y = i_neg ? -i_a : i_a;
endmodule

// File: rtl/exu_alu_muldiv.sv
// exu_alu_muldiv: shift-add RV32M multiplier borrowing the shared ALU adder each step
// MULDIV_EARLY_OUT_EN: skip the remaining iterations once the multiplier bits left are zero
module exu_alu_muldiv
   import exu_alu_muldiv_pkg::*;
#(
   parameter int XLEN  = `XLEN,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            rst,
   exu_alu_muldiv_if.slave io,
   output logic            muldiv_req_alu,
   output logic            muldiv_req_alu_add,
   output logic [XLEN-1:0] muldiv_req_alu_op1,
   output logic [XLEN-1:0] muldiv_req_alu_op2,
   input  logic            muldiv_req_alu_gnt,
   input  logic [XLEN-1:0] muldiv_req_alu_add_res
);
   muldiv_st_e        r_st;
   muldiv_op_e        r_op;
   logic [XLEN-1:0]   r_mcand;
   logic [XLEN-1:0]   r_wdat;
   logic [2*XLEN-1:0] r_prod;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_neg;
   logic              w_s1neg, w_s2neg, w_carry, w_step;
   logic [XLEN-1:0]   w_mcand, w_mplier, w_hi;
   logic [2*XLEN-1:0] w_fix, w_next;
   assign w_s1neg = rs1_signed(io.i_op) && io.i_rs1[XLEN-1];
   assign w_s2neg = io.i_op == MULDIV_OP_MULH && io.i_rs2[XLEN-1];
   muldiv_abs #(.W(XLEN))   u_abs_rs1 (.i_a(io.i_rs1), .i_neg(w_s1neg), .o_y(w_mcand));
   muldiv_abs #(.W(XLEN))   u_abs_rs2 (.i_a(io.i_rs2), .i_neg(w_s2neg), .o_y(w_mplier));
   muldiv_abs #(.W(2*XLEN)) u_abs_fix (.i_a(r_prod),   .i_neg(r_neg),   .o_y(w_fix));
   // Only the low XLEN sum bits come back, so the carry is recovered by wrap detection
   assign w_hi    = r_prod[2*XLEN-1:XLEN];
   assign w_carry = muldiv_req_alu_add_res < w_hi;
   assign w_step  = !r_prod[0] || muldiv_req_alu_gnt;
   assign w_next  = r_prod[0] ? {w_carry, muldiv_req_alu_add_res, r_prod[XLEN-1:1]} : r_prod >> 1;
`ifdef MULDIV_EARLY_OUT_EN
   logic             w_early;
   logic [CNT_W-1:0] w_sh;
   assign w_early = (r_prod[XLEN-1:0] & ({XLEN{1'b1}} >> r_cnt)) == '0;
   assign w_sh    = CNT_W'(XLEN) - r_cnt;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         r_st    <= MULDIV_ST_IDLE;
         r_op    <= MULDIV_OP_MUL;
         r_mcand <= '0;
         r_wdat  <= '0;
         r_prod  <= '0;
         r_cnt   <= '0;
         r_neg   <= 1'b0;
      end else if (io.i_flush) begin
         r_st   <= MULDIV_ST_IDLE;
         r_prod <= '0;
         r_cnt  <= '0;
      end else begin
         case (r_st)
            MULDIV_ST_IDLE: if (io.i_valid) begin
               r_st    <= MULDIV_ST_CALC;
               r_op    <= io.i_op;
               r_mcand <= w_mcand;
               r_neg   <= w_s1neg ^ w_s2neg;
               r_prod  <= {{XLEN{1'b0}}, w_mplier};
               r_cnt   <= '0;
            end
            MULDIV_ST_CALC: begin
`ifdef MULDIV_EARLY_OUT_EN
               if (w_early) begin
                  r_prod <= r_prod >> w_sh;
                  r_st   <= MULDIV_ST_FIX;
               end else
`endif
               if (w_step) begin
                  r_prod <= w_next;
                  r_cnt  <= r_cnt + 1'b1;
                  if (r_cnt == CNT_W'(XLEN-1)) r_st <= MULDIV_ST_FIX;
               end
            end
            MULDIV_ST_FIX: begin
               r_prod <= w_fix;
               r_wdat <= r_op == MULDIV_OP_MUL ? w_fix[XLEN-1:0] : w_fix[2*XLEN-1:XLEN];
               r_st   <= MULDIV_ST_DONE;
            end
            default: if (io.o_ready) r_st <= MULDIV_ST_IDLE;
         endcase
      end
   end
   assign io.i_ready         = r_st == MULDIV_ST_IDLE;
   assign io.o_valid         = r_st == MULDIV_ST_DONE;
   assign io.o_wdat          = r_wdat;
   assign muldiv_req_alu     = r_st == MULDIV_ST_CALC && r_prod[0];
   assign muldiv_req_alu_add = muldiv_req_alu;
   assign muldiv_req_alu_op1 = w_hi;
   assign muldiv_req_alu_op2 = r_mcand;
endmodule

// File: tb/tb_exu_alu_muldiv.sv
// tb_exu_alu_muldiv: scoreboard bench with a 66-bit arithmetic reference model
module tb_exu_alu_muldiv;
   import exu_alu_muldiv_pkg::*;
   logic clk = 1'b0, rst = 1'b1, req, req_add, gnt = 1'b1;
   logic [31:0] op1, op2, add_res;
   int n_chk = 0, n_fail = 0, granted = 0, denied = 0, gnt_mode = 0;
   logic [31:0] exp_q[$];
   logic p_hold = 1'b0;
   logic [31:0] p_op1, p_op2;
   always #5 clk = ~clk;
   exu_alu_muldiv_if #(.XLEN(32)) bus();
   assign add_res = op1 + op2;
   exu_alu_muldiv #(.XLEN(32), .CNT_W(6)) dut (
      .clk(clk), .rst(rst), .io(bus),
      .muldiv_req_alu(req), .muldiv_req_alu_add(req_add),
      .muldiv_req_alu_op1(op1), .muldiv_req_alu_op2(op2),
      .muldiv_req_alu_gnt(gnt), .muldiv_req_alu_add_res(add_res));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s act=%h exp=%h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_mul(input muldiv_op_e op, input logic [31:0] a, input logic [31:0] b);
      logic signed [65:0] x, y, p;
      x = {{34{(op == MULDIV_OP_MULH || op == MULDIV_OP_MULHSU) && a[31]}}, a};
      y = {{34{op == MULDIV_OP_MULH && b[31]}}, b};
      p = x * y;
      return op == MULDIV_OP_MUL ? p[31:0] : p[63:32];
   endfunction

   // Cycles spent in CALC when the datapath never denies a request
   function automatic int calc_cycles(input logic [31:0] mp);
`ifdef MULDIV_EARLY_OUT_EN
      int hb = -1;
      for (int i = 0; i < 32; i++) if (mp[i]) hb = i;
      return hb < 0 ? 1 : hb == 31 ? 32 : hb + 2;
`else
      return mp === 'x ? 0 : 32;
`endif
   endfunction

   always @(posedge clk) begin
      #1;
      gnt = gnt_mode == 0 ? 1'b1 : gnt_mode == 1 ? ~gnt : 1'($urandom_range(0, 1));
   end

   always @(negedge clk) begin
      if (!rst && bus.o_valid && bus.o_ready) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_o_valid act=%h exp=none", bus.o_wdat);
         end else chk("wdat", bus.o_wdat, exp_q.pop_front());
      end
      if (req) begin
         if (gnt) granted++;
         else denied++;
      end
      if (p_hold) begin
         chk("hold_req", 32'(req), 32'd1);
         chk("hold_op1", op1, p_op1);
         chk("hold_op2", op2, p_op2);
      end
      p_hold = !rst && req && !gnt && !bus.i_flush;
      p_op1  = op1;
      p_op2  = op2;
   end

   task automatic do_op(input muldiv_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit stall);
      int n = 0, g0 = granted, d0 = denied;
      logic [31:0] mp, w;
      mp = (op == MULDIV_OP_MULH && b[31]) ? -b : b;
      chk("i_ready_idle", 32'(bus.i_ready), 32'd1);
      bus.o_ready = !stall;
      bus.i_valid = 1'b1;
      bus.i_op = op;
      bus.i_rs1 = a;
      bus.i_rs2 = b;
      exp_q.push_back(exp);
      do begin
         @(posedge clk); #1;
         n++;
         bus.i_valid = 1'b0;
      end while (!bus.o_valid && n < 400);
      if (!bus.o_valid) begin
         chk("o_valid_timeout", 32'(bus.o_valid), 32'd1);
         void'(exp_q.pop_back());
         bus.o_ready = 1'b1;
         return;
      end
      chk("granted", 32'(granted - g0), 32'($countones(mp)));
      chk("latency", 32'(n), 32'(2 + calc_cycles(mp) + denied - d0));
      if (stall) begin
         w = bus.o_wdat;
         bus.i_valid = 1'b1;
         repeat (5) begin
            @(posedge clk); #1;
            chk("stall_valid", 32'(bus.o_valid), 32'd1);
            chk("stall_wdat", bus.o_wdat, w);
            chk("stall_i_ready", 32'(bus.i_ready), 32'd0);
         end
         bus.i_valid = 1'b0;
         bus.o_ready = 1'b1;
      end
      @(posedge clk); #1;
   endtask

   initial begin
      int nv;
      muldiv_op_e op;
      logic [31:0] a, b;
      bus.i_valid = 1'b0; bus.i_flush = 1'b0; bus.o_ready = 1'b1;
      bus.i_op = MULDIV_OP_MUL; bus.i_rs1 = '0; bus.i_rs2 = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_i_ready", 32'(bus.i_ready), 32'd1);
      chk("rst_o_valid", 32'(bus.o_valid), 32'd0);
      chk("rst_o_wdat", bus.o_wdat, 32'd0);
      chk("rst_req", 32'(req), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      do_op(MULDIV_OP_MUL,    32'd7,        32'd6,        32'd42,        1'b0);
      do_op(MULDIV_OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000,  1'b0);
      do_op(MULDIV_OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE,  1'b0);
      do_op(MULDIV_OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,  1'b0);
      do_op(MULDIV_OP_MUL,    32'h80000000, 32'h80000000, 32'h00000000,  1'b0);
      do_op(MULDIV_OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000,  1'b0);
      gnt_mode = 1;
      do_op(MULDIV_OP_MUL,    32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001,  1'b0);
      gnt_mode = 0;
      // Abort mid-calculation: nothing must come out
      bus.i_valid = 1'b1; bus.i_op = MULDIV_OP_MUL; bus.i_rs1 = 32'd3; bus.i_rs2 = 32'hFFFFFFFF;
      @(posedge clk); #1;
      bus.i_valid = 1'b0;
      repeat (9) begin @(posedge clk); #1; end
      bus.i_flush = 1'b1;
      @(posedge clk); #1;
      bus.i_flush = 1'b0;
      chk("flush_i_ready", 32'(bus.i_ready), 32'd1);
      chk("flush_o_valid", 32'(bus.o_valid), 32'd0);
      chk("flush_req", 32'(req), 32'd0);
      nv = 0;
      repeat (40) begin @(posedge clk); #1; nv += int'(bus.o_valid); end
      chk("flush_no_valid", 32'(nv), 32'd0);
      bus.i_valid = 1'b1; bus.i_flush = 1'b1;
      @(posedge clk); #1;
      bus.i_valid = 1'b0; bus.i_flush = 1'b0;
      chk("flush_accept_dropped", 32'(bus.i_ready), 32'd1);
      do_op(MULDIV_OP_MUL, 32'd3, 32'd5, 32'd15, 1'b0);
      do_op(MULDIV_OP_MUL, 32'd9, 32'd0, 32'd0,  1'b1);
      gnt_mode = 2;
      for (int i = 0; i < 30; i++) begin
         op = muldiv_op_e'($urandom_range(0, 3));
         a = $urandom();
         b = (i % 5 == 0) ? 32'h80000000 : (i % 7 == 0) ? 32'($urandom_range(0, 255)) : $urandom();
         do_op(op, a, b, ref_mul(op, a, b), i % 8 == 3);
      end
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout act=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule
